// File: rtl/mult_add_pipe_if.sv
// Handshake bundle for mult_add_pipe: operand beats in, scaled results out.
interface mult_add_pipe_if #(
    parameter int unsigned DATA_WIDTH = 20,
    parameter int unsigned N_TERMS    = 2
);
    logic                            in_valid;
    logic                            in_ready;
    logic                            in_last;
    logic [N_TERMS*DATA_WIDTH-1:0]   in_a;
    logic [N_TERMS*DATA_WIDTH-1:0]   in_b;
    logic                            out_valid;
    logic                            out_ready;
    logic [DATA_WIDTH-1:0]           out_data;
    logic                            out_ovf;

    modport master (
        output in_valid, in_last, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  in_valid, in_last, in_a, in_b, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/mult_add_pipe.sv
// Pipelined fixed-point dot-product engine: product stage, accumulator, scaled result register.
// Define MULT_ADD_SAT_EN to clamp out-of-range results (flagged on out_ovf) instead of wrapping.
module mult_add_pipe #(
    parameter int unsigned DATA_WIDTH = 20,
    parameter int unsigned FRAC       = 16,
    parameter int unsigned N_TERMS    = 2,
    parameter int unsigned ACC_GUARD  = 4
) (
    input logic              clk,
    input logic              rst,
    mult_add_pipe_if.slave   bus
);
    localparam int unsigned ProdW = 2 * DATA_WIDTH;
    localparam int unsigned AccW  = ProdW + $clog2(N_TERMS) + ACC_GUARD;

    logic signed [ProdW-1:0] prod_q  [N_TERMS];
    logic signed [ProdW-1:0] prod_in [N_TERMS];
    logic                    p_valid_q, p_valid_d;
    logic                    p_last_q;
    logic signed [AccW-1:0]  acc_q, acc_d;
    logic                    first_q, first_d;
    logic                    out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic                    out_ovf_q, out_ovf_d;

    logic                    p_adv, in_ready, accept, load_out;
    logic signed [AccW-1:0]  sum, base, total;
    logic [DATA_WIDTH-1:0]   scaled_data;
    logic                    scaled_ovf;

    always_comb begin
        // A last beat may only leave P when the result register can take it.
        p_adv    = p_valid_q && (!p_last_q || !out_valid_q || bus.out_ready);
        in_ready = !p_valid_q || p_adv;
        accept   = bus.in_valid && in_ready;
        load_out = p_adv && p_last_q;
        for (int i = 0; i < N_TERMS; i++) begin
            prod_in[i] = ProdW'($signed(bus.in_a[i*DATA_WIDTH +: DATA_WIDTH]))
                       * ProdW'($signed(bus.in_b[i*DATA_WIDTH +: DATA_WIDTH]));
        end
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < N_TERMS; i++) begin
            sum = sum + AccW'(prod_q[i]);
        end
        base  = first_q ? '0 : acc_q;
        total = base + sum;
    end

`ifdef MULT_ADD_SAT_EN
    logic signed [AccW-1:0]        shifted;
    logic [AccW-DATA_WIDTH:0]      hi;

    always_comb begin
        shifted = total >>> FRAC;
        hi      = shifted[AccW-1:DATA_WIDTH-1];
        // In range iff every bit above the result's sign bit matches it.
        if (&hi || ~|hi) begin
            scaled_data = shifted[DATA_WIDTH-1:0];
            scaled_ovf  = 1'b0;
        end else begin
            scaled_data = {shifted[AccW-1], {(DATA_WIDTH-1){~shifted[AccW-1]}}};
            scaled_ovf  = 1'b1;
        end
    end
`else
    always_comb begin
        scaled_data = total[FRAC +: DATA_WIDTH];
        scaled_ovf  = 1'b0;
    end
`endif

    always_comb begin
        p_valid_d   = p_valid_q;
        acc_d       = acc_q;
        first_d     = first_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;

        if (accept) begin
            p_valid_d = 1'b1;
        end else if (p_adv) begin
            p_valid_d = 1'b0;
        end

        if (p_adv) begin
            if (p_last_q) begin
                acc_d   = '0;
                first_d = 1'b1;
            end else begin
                acc_d   = total;
                first_d = 1'b0;
            end
        end

        if (load_out) begin
            out_valid_d = 1'b1;
            out_data_d  = scaled_data;
            out_ovf_d   = scaled_ovf;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_valid_q   <= 1'b0;
            p_last_q    <= 1'b0;
            acc_q       <= '0;
            first_q     <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
            for (int i = 0; i < N_TERMS; i++) begin
                prod_q[i] <= '0;
            end
        end else begin
            p_valid_q   <= p_valid_d;
            acc_q       <= acc_d;
            first_q     <= first_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
            if (accept) begin
                p_last_q <= bus.in_last;
                for (int i = 0; i < N_TERMS; i++) begin
                    prod_q[i] <= prod_in[i];
                end
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_mult_add_pipe.sv
// Scoreboard bench for mult_add_pipe: directed cases plus randomized dot products against a model.
module tb_mult_add_pipe;
    localparam int unsigned DW   = 20;
    localparam int unsigned FRAC = 16;
    localparam int unsigned NT   = 2;
    localparam int unsigned AG   = 4;
    localparam longint      SMAX = (64'sd1 <<< (DW - 1)) - 1;
    localparam longint      SMIN = -(64'sd1 <<< (DW - 1));

    typedef struct packed {
        logic [DW-1:0] data;
        logic          ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mult_add_pipe_if #(.DATA_WIDTH(DW), .N_TERMS(NT)) bus ();

    mult_add_pipe #(
        .DATA_WIDTH (DW),
        .FRAC       (FRAC),
        .N_TERMS    (NT),
        .ACC_GUARD  (AG)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int     n_cmp = 0;
    int     n_err = 0;
    longint acc_m = 0;
    exp_t   exp_q[$];
    exp_t   got_e;
    bit     held = 1'b0;
    bit     bp_low = 1'b0;
    logic [DW-1:0] held_data;
    logic          held_ovf;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: exact integer dot product, floor-shifted, then clamped or wrapped.
    function automatic void model_beat(input logic [NT*DW-1:0] a, input logic [NT*DW-1:0] b,
                                       input bit last);
        longint sc;
        exp_t   e;
        for (int i = 0; i < NT; i++) begin
            acc_m += longint'($signed(a[i*DW +: DW])) * longint'($signed(b[i*DW +: DW]));
        end
        if (last) begin
            sc    = acc_m >>> FRAC;
            e.ovf = 1'b0;
`ifdef MULT_ADD_SAT_EN
            if (sc > SMAX) begin
                sc    = SMAX;
                e.ovf = 1'b1;
            end else if (sc < SMIN) begin
                sc    = SMIN;
                e.ovf = 1'b1;
            end
`endif
            e.data = sc[DW-1:0];
            exp_q.push_back(e);
            acc_m = 0;
        end
    endfunction

    task automatic send(input logic [NT*DW-1:0] a, input logic [NT*DW-1:0] b, input bit last);
        int waitc = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_last  = last;
        #1;
        while (!bus.in_ready) begin
            if (waitc == 200) begin
                n_cmp++;
                n_err++;
                $display("FAIL send_timeout: in_ready stuck at 0, required 1 within 200 cycles");
                bus.in_valid = 1'b0;
                return;
            end
            waitc++;
            @(negedge clk);
            #1;
        end
        model_beat(a, b, last);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int c = 0;
        bus.out_ready = 1'b1;
        while ((exp_q.size() != 0 || bus.out_valid) && c < 200) begin
            @(negedge clk);
            c++;
        end
        check("drain_pending", 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: pops on every output transfer and checks hold-stability while stalled.
    always begin
        @(negedge clk);
        #2;
        if (rst) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check("stall_valid", 64'(bus.out_valid), 64'd1);
                check("stall_data", 64'(bus.out_data), 64'(held_data));
                check("stall_ovf", 64'(bus.out_ovf), 64'(held_ovf));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_result: got 0x%0h, required no result", bus.out_data);
                end else begin
                    got_e = exp_q.pop_front();
                    check("result_data", 64'(bus.out_data), 64'(got_e.data));
                    check("result_ovf", 64'(bus.out_ovf), 64'(got_e.ovf));
                end
            end
            held      = bus.out_valid && !bus.out_ready;
            held_data = bus.out_data;
            held_ovf  = bus.out_ovf;
            if (held && !bus.in_ready) bp_low = 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit done;
        logic [NT*DW-1:0] ra, rb;
        int nb;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_out_data", 64'(bus.out_data), 64'd0);
        check("reset_out_ovf", 64'(bus.out_ovf), 64'd0);
        check("reset_in_ready", 64'(bus.in_ready), 64'd1);

        // Single beat: 1.0*2.0 + 0.5*2.0 = 3.0, with latency check.
        send({20'h08000, 20'h10000}, {20'h20000, 20'h20000}, 1'b1);
        check("latency_edge_k", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        #1;
        check("latency_edge_k1", 64'(bus.out_valid), 64'd1);
        drain();

        // Three accumulated beats of 2.0 each.
        for (int i = 0; i < 3; i++) begin
            send({20'h10000, 20'h10000}, {20'h10000, 20'h10000}, i == 2);
        end
        drain();

        // Floor toward -inf: -1 LSB stays -1 LSB.
        send({20'h00000, 20'hFFFFF}, {20'h00000, 20'h00001}, 1'b1);
        drain();

        // Out of range: 49.0 + 49.0.
        send({20'h70000, 20'h70000}, {20'h70000, 20'h70000}, 1'b1);
        drain();

        // Backpressure on the first of four streamed results.
        bp_low = 1'b0;
        fork
            begin
                for (int i = 1; i <= 4; i++) begin
                    send({20'h00000, 20'(i << 16)}, {20'h00000, 20'h10000}, 1'b1);
                end
            end
            begin
                int c = 0;
                while (!bus.out_valid && c < 50) begin
                    @(negedge clk);
                    c++;
                end
                check("bp_first_result_seen", 64'(bus.out_valid), 64'd1);
                bus.out_ready = 1'b0;
                repeat (5) @(negedge clk);
                bus.out_ready = 1'b1;
            end
        join
        drain();
        check("bp_in_ready_dropped", 64'(bp_low), 64'd1);

        // Reset mid-accumulation discards the partial sum.
        send({20'h00000, 20'h20000}, {20'h00000, 20'h10000}, 1'b0);
        send({20'h00000, 20'h20000}, {20'h00000, 20'h10000}, 1'b0);
        @(negedge clk);
        rst   = 1'b1;
        acc_m = 0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        send({20'h00000, 20'h10000}, {20'h00000, 20'h10000}, 1'b1);
        drain();

        // Randomized dot products under random output backpressure.
        done = 1'b0;
        fork
            begin
                for (int p = 0; p < 40; p++) begin
                    nb = int'($urandom_range(1, 4));
                    for (int j = 0; j < nb; j++) begin
                        for (int l = 0; l < NT; l++) begin
                            ra[l*DW +: DW] = DW'($urandom);
                            rb[l*DW +: DW] = DW'($urandom);
                        end
                        if ($urandom % 4 == 0) @(negedge clk);
                        send(ra, rb, j == nb - 1);
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    bus.out_ready = ($urandom % 3) != 0;
                end
                bus.out_ready = 1'b1;
            end
        join
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mult_add_pipe.md
# mult_add_pipe

Pipelined, parametrised fixed-point dot-product engine: the next generation of the combinational two-term multiply-add. Each accepted beat multiplies N_TERMS signed operand pairs, sums the full-precision products, and accumulates the sum across beats until a `last` beat. The engine then emits one scaled DATA_WIDTH result. It sits between the operand-fetch logic and the result writeback in the compute datapath, with valid/ready handshakes on both sides.

## Interface
- DATA_WIDTH, 20, operand and result width (signed two's complement)
- FRAC, 16, fractional bits of operands and result
- N_TERMS, 2, operand pairs per beat (≥1)
- ACC_GUARD, 4, accumulator guard bits; supports 2^ACC_GUARD beats per result without internal overflow

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  beat valid
- in_ready  out  1  engine can accept beat
- in_last  in  1  final beat of current dot product
- in_a  in  N_TERMS*DATA_WIDTH  operand A lanes, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
- in_b  in  N_TERMS*DATA_WIDTH  operand B lanes, same packing
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  DATA_WIDTH  scaled result
- out_ovf  out  1  result was clamped (see Configuration)

## Operation
- Transfer on input when in_valid && in_ready; on output when out_valid && out_ready.
- Stage P (product register): on accept, prod[i] <= in_a[i]*in_b[i] (2*DATA_WIDTH signed, exact); p_last <= in_last; p_valid <= 1.
- Stage A (accumulator):
  - width ACC_W = 2*DATA_WIDTH + clog2(N_TERMS) + ACC_GUARD
  - sum = sign-extended sum of all prod[i]
  - base = 0 if `first` flag set, else acc
- Non-last P beat advances unconditionally: acc <= base + sum; first <= 0.
- Last P beat advances only if output register is free (!out_valid || out_ready), and then:
  - total = base + sum
  - out_data <= scale(total)
  - out_valid <= 1; first <= 1; acc <= 0
- scale(x): arithmetic right shift by FRAC (floor toward −∞, no rounding); then reduce to DATA_WIDTH per Configuration.
- Scaling is applied once, to the full-precision total. Per-product truncation does not exist.
- p_adv = p_valid && (!p_last || !out_valid || out_ready). p_valid clears on p_adv unless a new beat is accepted in the same cycle.
- in_ready = !p_valid || p_adv (combinational; single-entry skid-free pipeline).
- out_valid clears on output transfer unless a new last beat loads in the same cycle; simultaneous load and drain are legal.
- Accumulating more than 2^ACC_GUARD beats wraps acc silently (caller responsibility).
- in_last on the first beat is a single-beat dot product.

## Timing
- Reset values:
  - in_ready: 1 after the reset cycle
  - out_valid = 0, out_data = 0, out_ovf = 0
  - p_valid = 0, acc = 0, first = 1
- Reset mid-accumulation discards the partial sum and any pending P beat or unread result.
- Latency: last beat accepted at edge k → out_valid high after edge k+1 (result visible the cycle after P stage), given the output register is free.
- Throughput: one beat per cycle while out_ready is held high.
- Backpressure: with out_valid=1 and out_ready=0, a last beat stalls in P and in_ready drops in that cycle. Non-last beats behind a stalled last beat also stall. No beat is lost or reordered.
- out_data and out_ovf stay stable while out_valid && !out_ready.

## Configuration
- MULT_ADD_SAT_EN defined:
  - scaled value outside [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1] clamps to the nearest bound
  - out_ovf=1 with that result, else 0
- MULT_ADD_SAT_EN undefined:
  - out_data = low DATA_WIDTH bits of the scaled value (wrap)
  - out_ovf tied 0

## Test plan
- Single beat, defaults: a=(0x10000,0x08000), b=(0x20000,0x20000), last=1 → out_data=0x30000 (3.0) one cycle after P stage, out_ovf=0.
- Three beats, each a=(0x10000,0x10000), b=(0x10000,0x10000), last on third → exactly one result, 0x60000 (6.0).
- Floor: a=(0xFFFFF,0), b=(0x00001,0), last → out_data=0xFFFFF (−1 LSB, not 0).
- Overflow: a=(0x70000,0x70000), b=(0x70000,0x70000), last:
  - with MULT_ADD_SAT_EN → 0x7FFFF, out_ovf=1
  - without → 0x20000, out_ovf=0
- Backpressure: stream four single-beat products (1.0·1.0, 2.0·1.0, 3.0·1.0, 4.0·1.0) with out_ready low for 5 cycles after the first result → in_ready drops, results 0x10000, 0x20000, 0x30000, 0x40000 arrive in order, none dropped, out_data stable while stalled.
- Reset mid-op: two non-last beats of 2.0, rst for 1 cycle, then last beat 1.0·1.0 → out_data=0x10000, no residue from the earlier beats.
